mdv_select_ctrl: RTL and testbench

Microdrive controller between the ZX8302 microdrive control/status/data registers and up to eight microdrive replay units. Decodes the serial drive-select shift protocol into one-hot per-drive select lines. Multiplexes the selected drive's gap, byte-ready and data signals. Turns raw byte-ready and gap strobes into a latched receive buffer with overrun detection and a single-cycle gap interrupt pulse.

---
 rtl/mdv_select_ctrl_if.sv | 31 +++
 rtl/mdv_select_ctrl.sv | 138 +++++++++++++
 tb/tb_mdv_select_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdv_select_ctrl_if.sv
// CPU-side and drive-side signal bundle for the microdrive select controller.
// master drives the register strobes and per-drive inputs; slave is the controller.
interface mdv_select_ctrl_if #(
  parameter int NUM_DRIVES = 2
);
  logic                    ctrl_wr;
  logic [3:0]              ctrl_din;
  logic                    data_rd;
  logic [NUM_DRIVES-1:0]   gap_in;
  logic [NUM_DRIVES-1:0]   rx_ready_in;
  logic [8*NUM_DRIVES-1:0] dout_in;
  logic [NUM_DRIVES-1:0]   drv_sel;
  logic                    gap;
  logic                    gap_irq;
  logic                    rx_ready;
  logic [7:0]              rx_data;
  logic                    overrun;
  logic                    wr_en;
  logic                    erase;
  logic                    sel_conflict;

  modport master (
    output ctrl_wr, ctrl_din, data_rd, gap_in, rx_ready_in, dout_in,
    input  drv_sel, gap, gap_irq, rx_ready, rx_data, overrun, wr_en, erase, sel_conflict
  );

  modport slave (
    input  ctrl_wr, ctrl_din, data_rd, gap_in, rx_ready_in, dout_in,
    output drv_sel, gap, gap_irq, rx_ready, rx_data, overrun, wr_en, erase, sel_conflict
  );
endinterface

// File: rtl/mdv_select_ctrl.sv
// Microdrive select decoder, per-drive signal mux and receive buffer between
// the ZX8302 microdrive registers and up to eight replay units.
module mdv_select_ctrl #(
  parameter int NUM_DRIVES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mdv_select_ctrl_if.slave bus
);

  logic [7:0]              sr;
  logic                    sel_clk;
  logic                    wr_en_q;
  logic                    erase_q;
  logic [NUM_DRIVES-1:0]   drv_sel;
  logic                    sr_unused;

  logic [NUM_DRIVES-1:0]   gap_p1, gap_p2;
  logic [NUM_DRIVES-1:0]   rdy_p1, rdy_p2;
  logic [8*NUM_DRIVES-1:0] dout_p1;

  logic                    act_vld, prev_vld;
  logic [2:0]              act_idx, prev_idx;
  logic                    a_gap_p1, a_gap_p2, a_rdy_p1, a_rdy_p2;
  logic [7:0]              a_dout_p1;
  logic                    act_chg, gap_evt, byte_evt;

  logic                    gap_irq_q;
  logic                    rx_ready_q;
  logic                    overrun_q;
  logic [7:0]              rx_data_q;

  // Serial select protocol: data is shifted on a falling edge of the written clock bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      sel_clk <= 1'b0;
      wr_en_q <= 1'b0;
      erase_q <= 1'b0;
    end else if (bus.ctrl_wr) begin
      if (sel_clk && !bus.ctrl_din[1])
        sr <= {sr[6:0], bus.ctrl_din[0]};
      sel_clk <= bus.ctrl_din[1];
      wr_en_q <= bus.ctrl_din[2];
      erase_q <= bus.ctrl_din[3];
    end
  end

  assign drv_sel   = sr[NUM_DRIVES-1:0];
  assign sr_unused = sr[7];

  // Stage p1/p2: input sampling; histories reset high so a stale level is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_p1 <= '1;
      gap_p2 <= '1;
      rdy_p1 <= '1;
      rdy_p2 <= '1;
    end else begin
      gap_p1 <= bus.gap_in;
      gap_p2 <= gap_p1;
      rdy_p1 <= bus.rx_ready_in;
      rdy_p2 <= rdy_p1;
    end
  end

  always_ff @(posedge clk) begin
    dout_p1 <= bus.dout_in;
  end

  // Lowest selected index wins; descending loop leaves the lowest assignment last
  always_comb begin
    act_vld   = 1'b0;
    act_idx   = '0;
    a_gap_p1  = 1'b0;
    a_gap_p2  = 1'b0;
    a_rdy_p1  = 1'b0;
    a_rdy_p2  = 1'b0;
    a_dout_p1 = '0;
    for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
      if (drv_sel[i]) begin
        act_vld   = 1'b1;
        act_idx   = 3'(i);
        a_gap_p1  = gap_p1[i];
        a_gap_p2  = gap_p2[i];
        a_rdy_p1  = rdy_p1[i];
        a_rdy_p2  = rdy_p2[i];
        a_dout_p1 = dout_p1[8*i +: 8];
      end
    end
  end

  assign act_chg  = (act_vld != prev_vld) || (act_vld && (act_idx != prev_idx));
  assign gap_evt  = act_vld && !act_chg && a_gap_p1 && !a_gap_p2;
  assign byte_evt = act_vld && !act_chg && !wr_en_q && a_rdy_p1 && !a_rdy_p2;

  // Stage p2 -> outputs: interrupt pulse and receive buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vld   <= 1'b0;
      prev_idx   <= '0;
      gap_irq_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      rx_data_q  <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      prev_vld  <= act_vld;
      prev_idx  <= act_idx;
      gap_irq_q <= gap_evt;

      if (act_chg || wr_en_q || gap_evt)
        rx_ready_q <= 1'b0;
      else if (byte_evt)
        rx_ready_q <= 1'b1;
      else if (bus.data_rd)
        rx_ready_q <= 1'b0;

      if (byte_evt)
        rx_data_q <= a_dout_p1;

      if (bus.ctrl_wr)
        overrun_q <= 1'b0;
      else if (byte_evt && rx_ready_q && !bus.data_rd)
        overrun_q <= 1'b1;
    end
  end

  assign bus.drv_sel      = drv_sel;
  assign bus.gap          = act_vld ? a_gap_p1 : 1'b1;
  assign bus.gap_irq      = gap_irq_q;
  assign bus.rx_ready     = rx_ready_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.overrun      = overrun_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.erase        = erase_q;
  assign bus.sel_conflict = |(drv_sel & (drv_sel - NUM_DRIVES'(1)));

endmodule

// File: tb/tb_mdv_select_ctrl.sv
// Directed bench for mdv_select_ctrl: stimulus queues cycle-stamped expectations,
// an independent negedge monitor pops and compares them.
module tb_mdv_select_ctrl;

  localparam int N = 2;
  localparam int S_DRV = 0, S_GAP = 1, S_IRQ = 2, S_RDY = 3, S_DATA = 4,
                 S_OVR = 5, S_WREN = 6, S_ERASE = 7, S_CONF = 8;
  localparam int EXP_IRQ_PULSES = 3;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   irq_seen = 0;
  exp_t sb[$];

  mdv_select_ctrl_if #(.NUM_DRIVES(N)) bus();

  mdv_select_ctrl #(.NUM_DRIVES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int dly, input int sig, input int val, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic want_reset_state(input string tag);
    want(0, S_DRV,   0, {tag, "_drv"});
    want(0, S_GAP,   1, {tag, "_gap"});
    want(0, S_IRQ,   0, {tag, "_irq"});
    want(0, S_RDY,   0, {tag, "_rdy"});
    want(0, S_DATA,  0, {tag, "_data"});
    want(0, S_OVR,   0, {tag, "_ovr"});
    want(0, S_WREN,  0, {tag, "_wren"});
    want(0, S_ERASE, 0, {tag, "_erase"});
    want(0, S_CONF,  0, {tag, "_conf"});
  endtask

  task automatic wr_ctrl(input logic [3:0] d);
    bus.ctrl_wr  = 1'b1;
    bus.ctrl_din = d;
    tick();
    bus.ctrl_wr  = 1'b0;
  endtask

  function automatic int actual(input int sig);
    case (sig)
      S_DRV:   return int'(bus.drv_sel);
      S_GAP:   return int'(bus.gap);
      S_IRQ:   return int'(bus.gap_irq);
      S_RDY:   return int'(bus.rx_ready);
      S_DATA:  return int'(bus.rx_data);
      S_OVR:   return int'(bus.overrun);
      S_WREN:  return int'(bus.wr_en);
      S_ERASE: return int'(bus.erase);
      S_CONF:  return int'(bus.sel_conflict);
      default: return -1;
    endcase
  endfunction

  initial begin : monitor
    int a;
    forever begin
      @(negedge clk);
      if (bus.gap_irq === 1'b1) irq_seen++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          a = actual(sb[i].sig);
          if (a != sb[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", sb[i].name, cyc, a, sb[i].val);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s not sampled at cyc=%0d required=%0h", sb[i].name, sb[i].cyc, sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  initial begin : stim
    reset           = 1'b1;
    bus.ctrl_wr     = 1'b0;
    bus.ctrl_din    = 4'h0;
    bus.data_rd     = 1'b0;
    bus.gap_in      = '0;
    bus.rx_ready_in = '0;
    bus.dout_in     = '0;
    tick(); tick();
    want_reset_state("rst0");
    tick();
    reset = 1'b0;
    tick();

    // 1: select drive 1, gap follows, then shift to drive 2
    wr_ctrl(4'b0011); wr_ctrl(4'b0001);
    want(0, S_DRV, 1, "t1_sel_d1");
    want(0, S_GAP, 0, "t1_gap_low");
    want(0, S_CONF, 0, "t1_conf");
    bus.gap_in[0] = 1'b1;
    want(1, S_GAP, 1, "t1_gap_follow");
    want(2, S_IRQ, 1, "t1_irq");
    want(3, S_IRQ, 0, "t1_irq_end");
    tick(); tick(); tick();
    bus.gap_in[0] = 1'b0;
    tick(); tick();
    wr_ctrl(4'b0010); wr_ctrl(4'b0000);
    want(0, S_DRV, 2, "t1_sel_d2");
    want(0, S_GAP, 0, "t1_gap_d2");

    // 2: nothing selected, gap held at 1; then drive 2 gap edge
    wr_ctrl(4'b0010); wr_ctrl(4'b0000);
    want(0, S_DRV, 0, "t2_sel_none");
    want(0, S_GAP, 1, "t2_gap_none");
    bus.gap_in = 2'b11;
    want(1, S_GAP, 1, "t2_gap_tog_hi");
    tick(); tick();
    bus.gap_in = 2'b00;
    want(1, S_GAP, 1, "t2_gap_tog_lo");
    tick(); tick(); tick();
    wr_ctrl(4'b0011); wr_ctrl(4'b0001);
    wr_ctrl(4'b0010); wr_ctrl(4'b0000);
    want(0, S_DRV, 2, "t2_sel_d2");
    tick();
    bus.gap_in[1] = 1'b1;
    want(1, S_GAP, 1, "t2_gap_d2");
    want(1, S_IRQ, 0, "t2_irq_pre");
    want(2, S_IRQ, 1, "t2_irq");
    want(3, S_IRQ, 0, "t2_irq_end");
    tick(); tick(); tick(); tick();

    // 3: drive 1 byte A5, then CPU read
    wr_ctrl(4'b0011); wr_ctrl(4'b0001);
    want(0, S_DRV, 1, "t3_sel_d1");
    want(0, S_GAP, 0, "t3_gap_d1");
    tick();
    bus.dout_in = 16'h00A5;
    bus.rx_ready_in[0] = 1'b1;
    want(1, S_RDY, 0, "t3_rdy_lat1");
    want(2, S_RDY, 1, "t3_rdy");
    want(2, S_DATA, 8'hA5, "t3_data");
    tick(); tick(); tick();
    bus.rx_ready_in[0] = 1'b0;
    bus.data_rd = 1'b1;
    want(1, S_RDY, 0, "t3_rd_clr");
    want(1, S_DATA, 8'hA5, "t3_data_hold");
    tick();
    bus.data_rd = 1'b0;
    tick(); tick();

    // 4: two unread bytes -> overrun; ctrl write clears it
    bus.dout_in = 16'h0011;
    bus.rx_ready_in[0] = 1'b1;
    want(2, S_RDY, 1, "t4_rdy1");
    want(2, S_DATA, 8'h11, "t4_data1");
    tick();
    bus.rx_ready_in[0] = 1'b0;
    tick(); tick();
    bus.dout_in = 16'h0022;
    bus.rx_ready_in[0] = 1'b1;
    want(1, S_OVR, 0, "t4_ovr_pre");
    want(2, S_DATA, 8'h22, "t4_data2");
    want(2, S_OVR, 1, "t4_ovr");
    want(2, S_RDY, 1, "t4_rdy2");
    tick();
    bus.rx_ready_in[0] = 1'b0;
    tick();
    wr_ctrl(4'b0000);
    want(0, S_OVR, 0, "t4_ovr_clr");
    want(0, S_RDY, 1, "t4_rdy_keep");
    want(0, S_DRV, 1, "t4_drv_keep");

    // 5: byte coincident with read, then gap edge flushes
    bus.dout_in = 16'h0033;
    bus.rx_ready_in[0] = 1'b1;
    tick();
    bus.rx_ready_in[0] = 1'b0;
    bus.data_rd = 1'b1;
    want(1, S_RDY, 1, "t5_rdy_stay");
    want(1, S_DATA, 8'h33, "t5_data");
    want(1, S_OVR, 0, "t5_no_ovr");
    tick();
    bus.data_rd = 1'b0;
    tick(); tick();
    bus.gap_in[0] = 1'b1;
    want(1, S_GAP, 1, "t5_gap");
    want(1, S_RDY, 1, "t5_rdy_before_gap");
    want(2, S_IRQ, 1, "t5_irq");
    want(2, S_RDY, 0, "t5_flush");
    want(2, S_DATA, 8'h33, "t5_data_hold");
    want(3, S_IRQ, 0, "t5_irq_end");
    tick(); tick(); tick(); tick();

    // 6: write mode blocks capture; reset mid-operation; stale byte-ready
    wr_ctrl(4'b1100);
    want(0, S_WREN, 1, "t6_wren");
    want(0, S_ERASE, 1, "t6_erase");
    tick();
    bus.dout_in = 16'h0044;
    bus.rx_ready_in[0] = 1'b1;
    want(2, S_RDY, 0, "t6_wr_nocap");
    want(2, S_DATA, 8'h33, "t6_wr_data");
    tick(); tick(); tick();
    bus.rx_ready_in[0] = 1'b0;
    tick(); tick();
    wr_ctrl(4'b0000);
    want(0, S_WREN, 0, "t6_wren_off");
    want(0, S_ERASE, 0, "t6_erase_off");
    tick();
    bus.dout_in = 16'h005A;
    bus.rx_ready_in[0] = 1'b1;
    want(2, S_RDY, 1, "t6_cap");
    want(2, S_DATA, 8'h5A, "t6_cap_data");
    want(2, S_DRV, 1, "t6_cap_drv");
    tick(); tick(); tick();
    reset = 1'b1;
    want_reset_state("t6_rst");
    tick(); tick();
    reset = 1'b0;
    tick();
    wr_ctrl(4'b0011); wr_ctrl(4'b0001);
    want(0, S_DRV, 1, "t6_resel");
    want(0, S_GAP, 1, "t6_resel_gap");
    tick(); tick(); tick();
    want(0, S_RDY, 0, "t6_stale_nocap");
    want(0, S_DATA, 0, "t6_stale_data");
    tick();
    bus.rx_ready_in[0] = 1'b0;
    tick(); tick();
    bus.dout_in = 16'h0077;
    bus.rx_ready_in[0] = 1'b1;
    want(2, S_RDY, 1, "t6_recap");
    want(2, S_DATA, 8'h77, "t6_recap_data");
    tick();
    bus.rx_ready_in[0] = 1'b0;
    tick(); tick();
    wr_ctrl(4'b0011); wr_ctrl(4'b0001);
    want(0, S_DRV, 3, "t6_both_sel");
    want(0, S_CONF, 1, "t6_conflict");
    want(0, S_RDY, 1, "t6_conf_rdy_keep");
    want(0, S_GAP, 1, "t6_conf_gap");
    tick(); tick(); tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    checks++;
    if (irq_seen != EXP_IRQ_PULSES) begin
      errors++;
      $display("FAIL gap_irq_count actual=%0d required=%0d", irq_seen, EXP_IRQ_PULSES);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
